// File: rtl/grid_renderer.sv
// grid_renderer: 3-stage pixel pipeline that reads the 10x10 board memory
// and paints cells, grid lines, the mouse cursor and the blinking overlay.
module grid_renderer #(
  parameter int GRID_X0    = 160,
  parameter int GRID_Y0    = 80,
  parameter int CELL_SHIFT = 5,
  parameter int BLINK_BIT  = 4,
  parameter int SHOW_IA    = 0
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [3:0]  mouse_cell_x,
  input  logic [3:0]  mouse_cell_y,
  input  logic [4:0]  status_pointed_cell,
  input  logic [4:0]  cell_status_free,
  input  logic [4:0]  cell_status_player_occ,
  input  logic [4:0]  cell_status_ia_occ,
  input  logic [4:0]  cell_status_player_hitted,
  input  logic [4:0]  cell_status_ia_hitted,
  input  logic [4:0]  cell_status_player_and_ia_hitted,
  input  logic [4:0]  cell_status_pre_occupied,
  output logic [3:0]  pointer_cell_x,
  output logic [3:0]  pointer_cell_y,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int CELL   = 1 << CELL_SHIFT;
  localparam int GRID_W = 10 * CELL;

  typedef struct packed {
    logic vid;
    logic grid;
    logic line;
    logic cur;
    logic hs;
    logic vs;
  } flags_t;

  localparam flags_t FLAGS_RST = '{
    vid: 1'b0, grid: 1'b0, line: 1'b0,
    cur: 1'b0, hs: 1'b1, vs: 1'b1
  };

  logic [9:0]  dx, dy, ox, oy, cx, cy;
  logic        in_grid;
  flags_t      s1_d, s1_q, s2_q;
  logic [3:0]  ptr_x_d, ptr_x_q;
  logic [3:0]  ptr_y_d, ptr_y_q;
  logic [11:0] rgb_d, rgb_q;
  logic        hs_q, vs_q, vs_prev_q;
  logic [7:0]  frame_d, frame_q;

  function automatic logic band(input logic [9:0] o);
    return (o == 10'd1) || (o == 10'd2) ||
           (o == 10'(CELL - 3)) || (o == 10'(CELL - 2));
  endfunction

  assign dx = pixel_x - 10'(GRID_X0);
  assign dy = pixel_y - 10'(GRID_Y0);
  assign ox = dx & 10'(CELL - 1);
  assign oy = dy & 10'(CELL - 1);
  assign cx = dx >> CELL_SHIFT;
  assign cy = dy >> CELL_SHIFT;

  assign in_grid = (pixel_x >= 10'(GRID_X0)) &&
                   (dx < 10'(GRID_W)) &&
                   (pixel_y >= 10'(GRID_Y0)) &&
                   (dy < 10'(GRID_W));

  always_comb begin
    ptr_x_d = ptr_x_q;
    ptr_y_d = ptr_y_q;
    if (in_grid) begin
      ptr_x_d = cx[3:0];
      ptr_y_d = cy[3:0];
    end
    s1_d.vid  = video_on;
    s1_d.grid = in_grid;
    s1_d.line = (ox == 10'd0) || (oy == 10'd0) ||
                (dx == 10'(GRID_W - 1)) ||
                (dy == 10'(GRID_W - 1));
    // mouse values 10..15 can never equal an in-grid cell
    s1_d.cur  = (cx == {6'd0, mouse_cell_x}) &&
                (cy == {6'd0, mouse_cell_y}) &&
                (band(ox) || band(oy));
    s1_d.hs   = hsync_in;
    s1_d.vs   = vsync_in;
  end

  assign frame_d = frame_q + {7'd0, vs_prev_q & ~vsync_in};

  // status constants may alias, so the first match in this order wins
  always_comb begin
    rgb_d = 12'hF0F;
    if (!s2_q.vid)
      rgb_d = 12'h000;
    else if (!s2_q.grid)
      rgb_d = 12'h112;
    else if (s2_q.cur)
      rgb_d = 12'hFF0;
    else if (s2_q.line)
      rgb_d = 12'h000;
    else if (status_pointed_cell == cell_status_free)
      rgb_d = 12'h04C;
    else if (status_pointed_cell == cell_status_player_occ)
      rgb_d = 12'h888;
    else if (status_pointed_cell == cell_status_ia_occ)
      rgb_d = (SHOW_IA != 0) ? 12'h888 : 12'h04C;
    else if (status_pointed_cell == cell_status_player_hitted)
      rgb_d = 12'hF00;
    else if (status_pointed_cell == cell_status_ia_hitted)
      rgb_d = 12'hF80;
    else if (status_pointed_cell ==
             cell_status_player_and_ia_hitted)
      rgb_d = 12'hF0F;
    else if (status_pointed_cell == cell_status_pre_occupied)
      rgb_d = frame_q[BLINK_BIT] ? 12'h0F0 : 12'h888;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ptr_x_q   <= 4'd0;
      ptr_y_q   <= 4'd0;
      s1_q      <= FLAGS_RST;
      s2_q      <= FLAGS_RST;
      rgb_q     <= 12'h000;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
      frame_q   <= 8'd0;
    end else begin
      ptr_x_q   <= ptr_x_d;
      ptr_y_q   <= ptr_y_d;
      s1_q      <= s1_d;
      s2_q      <= s1_q;
      rgb_q     <= rgb_d;
      hs_q      <= s2_q.hs;
      vs_q      <= s2_q.vs;
      vs_prev_q <= vsync_in;
      frame_q   <= frame_d;
    end
  end

  assign pointer_cell_x = ptr_x_q;
  assign pointer_cell_y = ptr_y_q;
  assign rgb            = rgb_q;
  assign hsync_out      = hs_q;
  assign vsync_out      = vs_q;

endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: vector table, hand sequences for reset/sync/blink,
// and randomized pixels checked against a plain-arithmetic colour model.
module tb_grid_renderer;

  localparam logic [4:0] C_FREE = 5'd0;
  localparam logic [4:0] C_POCC = 5'd1;
  localparam logic [4:0] C_IOCC = 5'd2;
  localparam logic [4:0] C_PH   = 5'd3;
  localparam logic [4:0] C_IH   = 5'd4;
  localparam logic [4:0] C_PIH  = 5'd5;
  localparam logic [4:0] C_PRE  = 5'd6;
  localparam logic [4:0] C_BAD  = 5'd31;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b1, vsync_in = 1'b1;
  logic [3:0]  mouse_cell_x = 4'd15, mouse_cell_y = 4'd15;
  logic [4:0]  status = '0;
  logic [3:0]  px0, py0, px1, py1;
  logic [11:0] rgb0, rgb1;
  logic        hso0, vso0, hso1, vso1;
  logic [4:0]  mem [10][10];

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  always_ff @(posedge clk_in)
    status <= mem[px0][0] == 5'h1f ? mem[py0][px0] : mem[py0][px0];

  grid_renderer #(.SHOW_IA(0)) dut0 (
    .clk_in(clk_in), .rst_n(rst_n),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mouse_cell_x(mouse_cell_x), .mouse_cell_y(mouse_cell_y),
    .status_pointed_cell(status),
    .cell_status_free(C_FREE),
    .cell_status_player_occ(C_POCC),
    .cell_status_ia_occ(C_IOCC),
    .cell_status_player_hitted(C_PH),
    .cell_status_ia_hitted(C_IH),
    .cell_status_player_and_ia_hitted(C_PIH),
    .cell_status_pre_occupied(C_PRE),
    .pointer_cell_x(px0), .pointer_cell_y(py0),
    .rgb(rgb0), .hsync_out(hso0), .vsync_out(vso0)
  );

  grid_renderer #(.SHOW_IA(1)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mouse_cell_x(mouse_cell_x), .mouse_cell_y(mouse_cell_y),
    .status_pointed_cell(status),
    .cell_status_free(C_FREE),
    .cell_status_player_occ(C_POCC),
    .cell_status_ia_occ(C_IOCC),
    .cell_status_player_hitted(C_PH),
    .cell_status_ia_hitted(C_IH),
    .cell_status_player_and_ia_hitted(C_PIH),
    .cell_status_pre_occupied(C_PRE),
    .pointer_cell_x(px1), .pointer_cell_y(py1),
    .rgb(rgb1), .hsync_out(hso1), .vsync_out(vso1)
  );

  typedef struct {
    int px; int py; bit von; int mx; int my;
    logic [4:0] code;
    logic [11:0] e0; logic [11:0] e1;
    bit chk; int ex; int ey;
  } vec_t;

  typedef struct {
    int px; int py; bit von; int mx; int my;
    bit hs; bit vs; logic [4:0] code;
  } pix_t;

  vec_t tbl[$];
  pix_t pq[$];

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill(logic [4:0] c);
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++)
        mem[y][x] = c;
  endtask

  task automatic put(int px, int py, bit von, int mx, int my);
    @(negedge clk_in);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    video_on = von;
    mouse_cell_x = 4'(mx);
    mouse_cell_y = 4'(my);
  endtask

  task automatic do_reset;
    @(negedge clk_in);
    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
  endtask

  task automatic pulse;
    @(negedge clk_in);
    vsync_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    vsync_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic settle;
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  function automatic vec_t mk(int px, int py, bit von, int mx,
                              int my, logic [4:0] code,
                              logic [11:0] e0, logic [11:0] e1,
                              bit chk, int ex, int ey);
    vec_t v;
    v.px = px; v.py = py; v.von = von; v.mx = mx; v.my = my;
    v.code = code; v.e0 = e0; v.e1 = e1;
    v.chk = chk; v.ex = ex; v.ey = ey;
    return v;
  endfunction

  function automatic bit inband(int o);
    return o == 1 || o == 2 || o == 29 || o == 30;
  endfunction

  function automatic logic [11:0] ref_rgb(pix_t r, int fc, bit show);
    int dx, dy;
    if (!r.von) return 12'h000;
    if (r.px < 160 || r.px >= 480 || r.py < 80 || r.py >= 400)
      return 12'h112;
    dx = r.px - 160;
    dy = r.py - 80;
    if (dx / 32 == r.mx && dy / 32 == r.my &&
        (inband(dx % 32) || inband(dy % 32)))
      return 12'hFF0;
    if (dx % 32 == 0 || dy % 32 == 0 || dx == 319 || dy == 319)
      return 12'h000;
    case (r.code)
      C_FREE: return 12'h04C;
      C_POCC: return 12'h888;
      C_IOCC: return show ? 12'h888 : 12'h04C;
      C_PH:   return 12'hF00;
      C_IH:   return 12'hF80;
      C_PIH:  return 12'hF0F;
      C_PRE:  return ((fc / 16) % 2 == 1) ? 12'h0F0 : 12'h888;
      default: return 12'hF0F;
    endcase
  endfunction

  initial begin
    logic [4:0] codes [8];
    pix_t r;
    int fc, mx, my;
    bit pvs;
    codes = '{C_FREE, C_POCC, C_IOCC, C_PH, C_IH, C_PIH, C_PRE, C_BAD};
    fill(C_FREE);

    // reset with random inputs
    repeat (2) begin
      @(negedge clk_in);
      rst_n = 1'b0;
      pixel_x = 10'($urandom_range(0, 639));
      pixel_y = 10'($urandom_range(0, 479));
      video_on = 1'($urandom);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      mouse_cell_x = 4'($urandom);
      mouse_cell_y = 4'($urandom);
      @(posedge clk_in);
    end
    #1;
    check("rst_rgb", rgb0, 12'h000);
    check("rst_hs", hso0, 1);
    check("rst_vs", vso0, 1);
    check("rst_ptr", {px0, py0}, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    put(170, 90, 1, 15, 15);
    tick;
    check("lat_ptr", {px0, py0}, 0);
    tick;
    check("lat_e2", rgb0, 12'h000);
    tick;
    check("lat_e3", rgb0, 12'h04C);

    // sync delay
    @(negedge clk_in);
    hsync_in = 1'b0;
    tick;
    @(negedge clk_in);
    hsync_in = 1'b1;
    tick;
    check("hs_e2", hso0, 1);
    tick;
    check("hs_e3", hso0, 0);
    tick;
    check("hs_e4", hso0, 1);

    tbl.push_back(mk(170, 90, 1, 15, 15, C_FREE, 12'h04C, 12'h04C, 1, 0, 0));
    tbl.push_back(mk(479, 399, 1, 15, 15, C_FREE, 12'h000, 12'h000, 1, 9, 9));
    tbl.push_back(mk(192, 100, 1, 15, 15, C_FREE, 12'h000, 12'h000, 1, 1, 0));
    tbl.push_back(mk(159, 100, 1, 15, 15, C_FREE, 12'h112, 12'h112, 0, 0, 0));
    tbl.push_back(mk(480, 100, 1, 15, 15, C_FREE, 12'h112, 12'h112, 0, 0, 0));
    tbl.push_back(mk(100, 100, 0, 15, 15, C_FREE, 12'h000, 12'h000, 0, 0, 0));
    tbl.push_back(mk(225, 180, 1, 2, 3, C_FREE, 12'hFF0, 12'hFF0, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 2, 3, C_FREE, 12'h04C, 12'h04C, 1, 2, 3));
    tbl.push_back(mk(225, 180, 1, 12, 3, C_FREE, 12'h04C, 12'h04C, 1, 2, 3));
    tbl.push_back(mk(254, 200, 1, 2, 3, C_FREE, 12'hFF0, 12'hFF0, 1, 2, 3));
    tbl.push_back(mk(255, 200, 1, 2, 3, C_FREE, 12'h04C, 12'h04C, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_FREE, 12'h04C, 12'h04C, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_POCC, 12'h888, 12'h888, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_IOCC, 12'h04C, 12'h888, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_PH, 12'hF00, 12'hF00, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_IH, 12'hF80, 12'hF80, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_PIH, 12'hF0F, 12'hF0F, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_PRE, 12'h888, 12'h888, 1, 2, 3));
    tbl.push_back(mk(240, 190, 1, 15, 15, C_BAD, 12'hF0F, 12'hF0F, 1, 2, 3));

    foreach (tbl[i]) begin
      fill(tbl[i].code);
      put(tbl[i].px, tbl[i].py, tbl[i].von, tbl[i].mx, tbl[i].my);
      tick;
      if (tbl[i].chk) begin
        check($sformatf("ptr_x[%0d]", i), px0, tbl[i].ex);
        check($sformatf("ptr_y[%0d]", i), py0, tbl[i].ey);
      end
      tick;
      tick;
      check($sformatf("rgb0[%0d]", i), rgb0, tbl[i].e0);
      check($sformatf("rgb1[%0d]", i), rgb1, tbl[i].e1);
    end

    // blink, wrap and long vsync low
    do_reset;
    fill(C_PRE);
    put(240, 190, 1, 15, 15);
    repeat (15) pulse;
    settle;
    check("blink15", rgb0, 12'h888);
    pulse;
    settle;
    check("blink16", rgb0, 12'h0F0);
    repeat (239) pulse;
    settle;
    check("cnt255", rgb0, 12'h0F0);
    pulse;
    settle;
    check("wrap256", rgb0, 12'h888);
    @(negedge clk_in);
    vsync_in = 1'b0;
    repeat (20) @(negedge clk_in);
    vsync_in = 1'b1;
    settle;
    check("vs_low_once", rgb0, 12'h888);
    repeat (15) pulse;
    settle;
    check("vs_low_then15", rgb0, 12'h0F0);

    // randomized against reference model
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++)
        mem[y][x] = codes[$urandom_range(0, 7)];
    @(negedge clk_in);
    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    fc = 0;
    pvs = 1'b1;
    mx = 0;
    my = 0;
    pq.delete();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_in);
      rst_n = 1'b1;
      r.px = $urandom_range(150, 500);
      r.py = $urandom_range(70, 420);
      r.von = ($urandom_range(0, 9) != 0);
      r.mx = $urandom_range(0, 15);
      r.my = $urandom_range(0, 15);
      r.hs = 1'($urandom);
      r.vs = ($urandom_range(0, 3) != 0);
      if (r.px >= 160 && r.px < 480 && r.py >= 80 && r.py < 400) begin
        mx = (r.px - 160) / 32;
        my = (r.py - 80) / 32;
      end
      r.code = mem[my][mx];
      pixel_x = 10'(r.px);
      pixel_y = 10'(r.py);
      video_on = r.von;
      mouse_cell_x = 4'(r.mx);
      mouse_cell_y = 4'(r.my);
      hsync_in = r.hs;
      vsync_in = r.vs;
      pq.push_back(r);
      tick;
      check("rnd_ptr0", {px0, py0}, (mx << 4) | my);
      check("rnd_ptr1", {px1, py1}, (mx << 4) | my);
      if (pq.size() >= 3) begin
        r = pq.pop_front();
        check($sformatf("rnd_rgb0 n=%0d", n), rgb0, ref_rgb(r, fc, 0));
        check($sformatf("rnd_rgb1 n=%0d", n), rgb1, ref_rgb(r, fc, 1));
        check("rnd_hs", hso0, r.hs);
        check("rnd_vs", vso0, r.vs);
      end
      if (pvs && !vsync_in) fc = (fc + 1) % 256;
      pvs = vsync_in;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_renderer.md
# grid_renderer

Pixel-side reader of the 10x10 game-board cell memory. It receives the current VGA pixel coordinate and drives the memory's pointer read port (`pointer_cell_x/y`). It takes the returned `status_pointed_cell` and produces registered 12-bit RGB, with grid lines, a mouse-cursor highlight and a blinking pre-placement overlay. Sync signals are delayed to match the pixel pipeline. It sits between the VGA timing generator and the DAC/pin outputs.

## Interface
Parameters:
- `GRID_X0`, 160: left pixel column of the board.
- `GRID_Y0`, 80: top pixel row of the board.
- `CELL_SHIFT`, 5: log2 of the cell size. Cells are 32x32 px, so the board is 320x320 px.
- `BLINK_BIT`, 4: frame-counter bit that drives the blink. Period is 2*2^BLINK_BIT frames.
- `SHOW_IA`, 0: 1 shows AI ships; 0 hides them as water.

Ports:
- `clk_in`: input, 1 bit. Pixel clock.
- `rst_n`: input, 1 bit. Reset, synchronous, active-low.
- `pixel_x`: input, 10 bits. Current pixel column.
- `pixel_y`: input, 10 bits. Current pixel row.
- `video_on`: input, 1 bit. High inside the visible area.
- `hsync_in`: input, 1 bit. Horizontal sync, active-low.
- `vsync_in`: input, 1 bit. Vertical sync, active-low.
- `mouse_cell_x`, `mouse_cell_y`: input, 4 bits each. Cursor cell.
- `status_pointed_cell`: input, 5 bits. Memory read data, registered by the memory on `posedge clk_in`.
- `cell_status_free`, `cell_status_player_occ`, `cell_status_ia_occ`, `cell_status_player_hitted`, `cell_status_ia_hitted`, `cell_status_player_and_ia_hitted`, `cell_status_pre_occupied`: input, 5 bits each. Status code constants.
- `pointer_cell_x`, `pointer_cell_y`: output, 4 bits each. Registered memory read address.
- `rgb`: output, 12 bits. Colour as {R[3:0], G[3:0], B[3:0]}.
- `hsync_out`: output, 1 bit. `hsync_in` delayed 3 cycles.
- `vsync_out`: output, 1 bit. `vsync_in` delayed 3 cycles.

## Operation
- **Stage 1 (edge k).**
  - Compute `dx = pixel_x - GRID_X0` and `dy = pixel_y - GRID_Y0` at 10 bits.
  - `in_grid` is true when `pixel_x >= GRID_X0`, `dx < 320`, `pixel_y >= GRID_Y0` and `dy < 320`.
  - If `in_grid`, register `pointer_cell_x = dx >> CELL_SHIFT` and `pointer_cell_y = dy >> CELL_SHIFT`, which always fall in 0..9. Otherwise hold the previous value.
  - Register these flags:
    - `in_grid`.
    - `video_on`.
    - `line`: low 5 bits of dx or dy equal 0, or dx==319, or dy==319.
    - `cursor`: the cell equals the mouse cell and the low 5 bits of dx or dy are in {1,2,29,30}.
    - Both syncs.
- **Stage 2 (edge k+1).** The memory registers the status. This block only shifts the stage-1 flags and syncs.
- **Stage 3 (edge k+2).** Register `rgb` and the syncs using this priority, highest first:
  1. `!video_on` gives 0x000.
  2. `!in_grid` gives background 0x112.
  3. `cursor` gives 0xFF0.
  4. `line` gives 0x000.
  5. Otherwise decode the status:
     - free gives 0x04C.
     - player_occ gives 0x888.
     - ia_occ gives 0x888 if SHOW_IA, else 0x04C.
     - player_hitted gives 0xF00.
     - ia_hitted gives 0xF80.
     - player_and_ia_hitted gives 0xF0F.
     - pre_occupied gives 0x0F0 when `frame_cnt[BLINK_BIT]` is 1, else 0x888.
     - Any other code gives 0xF0F (debug).
- Status codes are compared in the order listed above; the first match wins. This covers the case where constants are duplicated.
- **Frame counter.**
  - `frame_cnt` is 8 bits and wraps from 255 to 0.
  - It increments by 1 on the cycle where a registered copy of `vsync_in` is 1 and the current `vsync_in` is 0 (falling edge).
  - One increment per vsync pulse.
- **Cursor.** `mouse_cell` values 10..15 never match a cell, so no highlight is drawn. Cursor inputs are sampled in stage 1 without synchronisation.
- **Reset** (`rst_n`=0 at an edge): on the next edge, `rgb`=0, `pointer_cell_x/y`=0, `hsync_out`=`vsync_out`=1, `frame_cnt`=0, all pipeline flags 0, sync pipeline stages 1.
  - Reset mid-frame discards in-flight pixels.
  - Output resumes correct data 3 cycles after release.

## Timing
- Latency is 3 clock edges from `pixel_x/y/video_on/sync` to `rgb/hsync_out/vsync_out`. Syncs and colour stay aligned.
- `pointer_cell_x/y` is 1 cycle after the pixel. `status_pointed_cell` is consumed 2 edges after the pixel, and colour is produced at the 3rd.
- Throughput is one pixel per clock, with no stalls and no handshake.
- Memory writes occur on `negedge`. A cell changed mid-frame shows its new colour from the next pixel read onward; tearing is acceptable.

## Test plan
- **Reset.** Hold `rst_n`=0 for 2 cycles with random inputs -> `rgb`=0x000, `hsync_out`=`vsync_out`=1, `pointer_cell`=0. Release -> first valid colour appears 3 cycles later.
- **Address and latency.**
  - Drive pixel (170,90) with `video_on`=1 -> `pointer_cell`=(0,0) at the next edge.
  - Model the memory returning free.
  - `rgb`=0x04C exactly 3 edges after the input.
  - Pixel (479,399) -> `pointer_cell`=(9,9).
- **Grid and boundaries.**
  - Pixel (192,100) -> 0x000 (line).
  - (159,100) -> 0x112.
  - (480,100) -> 0x112.
  - (100,100) with `video_on`=0 -> 0x000.
- **Cursor.**
  - Mouse (2,3), pixel (225,180) -> 0xFFF0... specifically 0xFF0 (cursor).
  - Pixel (240,190) in the same cell -> status colour.
  - Mouse (12,3) -> no highlight.
- **Status decode.** Step through all seven codes plus code 31. Verify each colour. Verify ia_occ with SHOW_IA=0 and with SHOW_IA=1.
- **Blink and wrap.**
  - Feed 16 vsync pulses with a pre_occupied cell -> colour changes from 0x888 to 0x0F0 after the 16th pulse.
  - 256 pulses -> `frame_cnt` wraps to 0.
  - `vsync_in` held low for several lines counts once.
